ate_frame_ctrl: RTL and testbench
=================================

ATE_FRAME_CTRL -- requirements
Module: ate_frame_ctrl

Interface
REQ-001 Parameter BLK_COLS, default 6, image width in 8x8 blocks (1..8).
REQ-002 Parameter BLK_ROWS, default 4, image height in 8x8 blocks (1..8).
REQ-003 Parameter ADDR_W, default 12, image memory address width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame request; sampled only in IDLE.
REQ-007 hold  input  1  freezes address generation while high.
REQ-008 mem_rdata  input  8  image memory read data, valid one cycle after mem_rd.
REQ-009 mem_rd  output  1  image memory read strobe.
REQ-010 mem_addr  output  ADDR_W  raster address of the pixel being read.
REQ-011 pix_data  output  8  registered pixel to threshold engine.
REQ-012 pix_valid  output  1  pix_data qualifier.
REQ-013 blk_first  output  1  high with the first pixel (x=0, y=0) of each block.
REQ-014 border  output  1  high for every pixel of a block in column 0 or column BLK_COLS-1.
REQ-015 busy  output  1  high in FETCH and DRAIN.
REQ-016 done  output  1  one-cycle pulse at frame end.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DRAIN, DONE.
REQ-018 IDLE -> FETCH on start=1; counters x, y (0..7), bx (0..BLK_COLS-1), by (0..BLK_ROWS-1) cleared on entry.
REQ-019 In FETCH with hold=0, mem_rd=1 and mem_addr=(by*8+y)*(BLK_COLS*8)+(bx*8+x), truncated to ADDR_W.
REQ-020 Scan order SHALL be x fastest, then y, then bx, then by (block-by-block, raster inside each block).
REQ-021 x wraps 7->0 incrementing y; y wraps 7->0 incrementing bx; bx wraps BLK_COLS-1->0 incrementing by.
REQ-022 In FETCH with hold=1, mem_rd=0, mem_addr and all counters held; already-issued reads still complete.
REQ-023 FETCH -> DRAIN after issuing the read with x=7, y=7, bx=BLK_COLS-1, by=BLK_ROWS-1.
REQ-024 Read pipeline: pix_valid, pix_data=mem_rdata, blk_first and border SHALL appear exactly 2 cycles after the corresponding mem_rd cycle.
REQ-025 blk_first and border SHALL be 0 whenever pix_valid=0.
REQ-026 DRAIN -> DONE in the cycle after the last pix_valid; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-027 Total pix_valid cycles per frame SHALL equal BLK_COLS*BLK_ROWS*64 (1536 at defaults).
REQ-028 start while busy or in DONE SHALL be ignored; start held high in IDLE after DONE SHALL launch a new frame.
REQ-029 hold in IDLE, DRAIN or DONE SHALL have no effect.
REQ-030 mem_rd=0 in every state except FETCH.

Reset
REQ-031 reset=0 SHALL force, asynchronously: state=IDLE, all counters 0, mem_rd=0, mem_addr=0, pix_data=0, pix_valid=0, blk_first=0, border=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL discard in-flight reads; no pix_valid after reset release until a new start.

Verification
REQ-033 Defaults, start pulse, hold=0 -> first mem_rd at cycle after start with mem_addr=0; addresses 0..7, 48..55 for block 0; pix_valid run of 1536 cycles; done 1 cycle after last pixel.
REQ-034 Block 1 first read -> mem_addr=8 with blk_first=1 two cycles later; block 6 (bx=0,by=1) first read -> mem_addr=384.
REQ-035 border check at defaults -> border=1 for blocks 0,5,6,11,12,17,18,23, 0 for all others.
REQ-036 hold=1 for 5 cycles mid-block -> mem_addr frozen, exactly 5 pix_valid gaps, no pixel lost or duplicated (compare against memory model).
REQ-037 reset=0 during block 10 -> all outputs 0 immediately; after release, start -> frame restarts at mem_addr=0.
REQ-038 BLK_COLS=1, BLK_ROWS=1 -> 64 pixels, border=1 throughout, blk_first once, done once; start during busy ignored.

Source files
------------

// File: rtl/ate_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// ate_frame_ctrl_if
// Bundles the image-memory read port and the pixel stream that feeds the
// threshold engine.
//
//   mem_rd     read strobe toward image memory
//   mem_addr   raster address of the pixel being read (ADDR_W bits)
//   mem_rdata  read data from memory, valid one cycle after mem_rd
//   pix_data   registered pixel toward the threshold engine
//   pix_valid  pix_data qualifier
//   blk_first  first pixel (x=0, y=0) of an 8x8 block
//   border     pixel belongs to a block in the first or last block column
//
// Modports: master = frame controller, slave = memory / pixel consumer.
// ---------------------------------------------------------------------------
interface ate_frame_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              blk_first;
    logic              border;

    modport master (
        output mem_rd, mem_addr, pix_data, pix_valid, blk_first, border,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr, pix_data, pix_valid, blk_first, border,
        output mem_rdata
    );
endinterface

// File: rtl/ate_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ate_frame_ctrl
// Walks an image stored in raster order block by block (8x8 blocks, raster
// inside each block), issues one memory read per pixel and forwards the
// returned pixels with block sideband flags two cycles after each read.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   start  frame request, only looked at in IDLE
//   hold   stalls address generation while in FETCH
//   bus    memory read port + pixel stream (master side)
//   busy   high while fetching or draining the read pipeline
//   done   one-cycle pulse at the end of a frame
// ---------------------------------------------------------------------------
module ate_frame_ctrl #(
    parameter int BLK_COLS = 6,
    parameter int BLK_ROWS = 4,
    parameter int ADDR_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    ate_frame_ctrl_if.master bus,
    output logic             busy,
    output logic             done
);
    localparam int BX_W = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
    localparam int BY_W = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
    localparam logic [BX_W-1:0] BX_MAX  = BX_W'(BLK_COLS - 1);
    localparam logic [BY_W-1:0] BY_MAX  = BY_W'(BLK_ROWS - 1);
    localparam logic [31:0]     ROW_PIX = 32'(BLK_COLS * 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      x;
    logic [2:0]      y;
    logic [BX_W-1:0] bx;
    logic [BY_W-1:0] by;
    logic            issue;
    logic            last_rd;

    logic            rd_vld_p0;
    logic            first_p0;
    logic            border_p0;
    logic            pix_vld_p1;
    logic [7:0]      pix_data_p1;
    logic            first_p1;
    logic            border_p1;

    assign last_rd = (x == 3'd7) && (y == 3'd7) && (bx == BX_MAX) && (by == BY_MAX);

    // Address is a pure function of the counters, so it stays frozen while
    // hold keeps the counters from advancing.
    assign bus.mem_addr = ADDR_W'((32'(by) * 32'd8 + 32'(y)) * ROW_PIX
                                  + 32'(bx) * 32'd8 + 32'(x));
    assign bus.mem_rd   = issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                issue = !hold;
                if (!hold && last_rd) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The pixel on the output now is the last one when nothing
                // is left in the first pipeline stage.
                if (pix_vld_p1 && !rd_vld_p0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Scan counters: x fastest, then y, then bx, then by. The final read
    // returns everything to zero so the next frame starts clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x  <= 3'd0;
            y  <= 3'd0;
            bx <= '0;
            by <= '0;
        end else if ((state == IDLE && start) || (issue && last_rd)) begin
            x  <= 3'd0;
            y  <= 3'd0;
            bx <= '0;
            by <= '0;
        end else if (issue) begin
            if (x != 3'd7) begin
                x <= x + 3'd1;
            end else begin
                x <= 3'd0;
                if (y != 3'd7) begin
                    y <= y + 3'd1;
                end else begin
                    y <= 3'd0;
                    if (bx != BX_MAX) begin
                        bx <= bx + BX_W'(1);
                    end else begin
                        bx <= '0;
                        by <= by + BY_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_p0   <= 1'b0;
            first_p0    <= 1'b0;
            border_p0   <= 1'b0;
            pix_vld_p1  <= 1'b0;
            pix_data_p1 <= 8'd0;
            first_p1    <= 1'b0;
            border_p1   <= 1'b0;
        end else begin
            // ---- stage p0: read issued, memory is fetching ----
            rd_vld_p0   <= issue;
            first_p0    <= issue && (x == 3'd0) && (y == 3'd0);
            border_p0   <= issue && ((bx == '0) || (bx == BX_MAX));
            // ---- stage p1: capture returned data with its sideband ----
            pix_vld_p1  <= rd_vld_p0;
            first_p1    <= rd_vld_p0 && first_p0;
            border_p1   <= rd_vld_p0 && border_p0;
            if (rd_vld_p0) begin
                pix_data_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.pix_valid = pix_vld_p1;
    assign bus.pix_data  = pix_data_p1;
    assign bus.blk_first = first_p1;
    assign bus.border    = border_p1;
endmodule

// File: tb/tb_ate_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ate_frame_ctrl
// Bench for ate_frame_ctrl: a 6x4-block instance and a 1x1-block instance,
// each with its own random-filled image memory. Expected addresses, pixels
// and flags come from an arithmetic model of the block scan.
// ---------------------------------------------------------------------------
module tb_ate_frame_ctrl;
    localparam int COLS = 6;
    localparam int ROWS = 4;
    localparam int NPIX = COLS * ROWS * 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a = 1'b0;
    logic hold_a  = 1'b0;
    logic start_b = 1'b0;
    logic hold_b  = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ate_frame_ctrl_if #(.ADDR_W(12)) bus_a ();
    ate_frame_ctrl_if #(.ADDR_W(12)) bus_b ();

    ate_frame_ctrl #(.BLK_COLS(COLS), .BLK_ROWS(ROWS), .ADDR_W(12)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .hold(hold_a),
        .bus(bus_a), .busy(busy_a), .done(done_a)
    );

    ate_frame_ctrl #(.BLK_COLS(1), .BLK_ROWS(1), .ADDR_W(12)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .hold(hold_b),
        .bus(bus_b), .busy(busy_b), .done(done_b)
    );

    logic [7:0] mem_a [0:4095];
    logic [7:0] mem_b [0:63];

    always @(posedge clk) if (bus_a.mem_rd) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    always @(posedge clk) if (bus_b.mem_rd) bus_b.mem_rdata <= mem_b[bus_b.mem_addr[5:0]];

    // Observation logs for instance A (sampled on the falling edge)
    int         rd_addr_q [$];
    int         rd_cyc_q  [$];
    logic [9:0] pix_q     [$];
    int         pix_cyc_q [$];
    int         hold_cyc_q[$];
    int         done_cnt    = 0;
    int         done_cyc    = -1;
    int         side_bad    = 0;
    int         rd_in_hold  = 0;

    always @(negedge clk) begin
        if (bus_a.mem_rd) begin
            rd_addr_q.push_back(int'(bus_a.mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (hold_a && bus_a.mem_rd) rd_in_hold <= rd_in_hold + 1;
        if (hold_a) hold_cyc_q.push_back(cyc);
        if (bus_a.pix_valid) begin
            pix_q.push_back({bus_a.blk_first, bus_a.border, bus_a.pix_data});
            pix_cyc_q.push_back(cyc);
        end else if (bus_a.blk_first || bus_a.border) begin
            side_bad <= side_bad + 1;
        end
        if (done_a) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Observation for instance B
    int b_pix = 0, b_brd = 0, b_first = 0, b_bad = 0, b_side = 0;
    int b_rd_q  [$];
    int b_done_q[$];

    always @(negedge clk) begin
        if (bus_b.mem_rd) b_rd_q.push_back(cyc);
        if (bus_b.pix_valid) begin
            b_pix <= b_pix + 1;
            if (bus_b.border)    b_brd   <= b_brd + 1;
            if (bus_b.blk_first) b_first <= b_first + 1;
            if (bus_b.pix_data !== mem_b[b_pix % 64]) b_bad <= b_bad + 1;
        end else if (bus_b.blk_first || bus_b.border) begin
            b_side <= b_side + 1;
        end
        if (done_b) b_done_q.push_back(cyc);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raster address of the k-th pixel in block scan order.
    function automatic int addr_of(input int k, input int cols);
        int blk;
        blk = k / 64;
        return ((blk / cols) * 8 + (k % 64) / 8) * (cols * 8) + (blk % cols) * 8 + (k % 8);
    endfunction

    function automatic logic [9:0] pix_of(input int k);
        int blk;
        logic f, b;
        blk = k / 64;
        f = ((k % 64) == 0);
        b = ((blk % COLS) == 0) || ((blk % COLS) == COLS - 1);
        return {f, b, mem_a[addr_of(k, COLS)]};
    endfunction

    task automatic run_frame_a(input int pct, input int hold_at, input int hold_len,
                               input int exp_gaps, input string tag,
                               output int rb, output int pb);
        int hb, db, sb, rhb, s_cyc, t, nrd, npx;
        int bad_addr, bad_pix, bad_lat, bad_frz;
        int first_rd, last_rd, first_px, last_px, hw, hi, c;
        rb = rd_addr_q.size(); pb = pix_q.size(); hb = hold_cyc_q.size();
        db = done_cnt; sb = side_bad; rhb = rd_in_hold;
        bad_addr = 0; bad_pix = 0; bad_lat = 0; bad_frz = 0; hw = 0; hi = 0;
        start_a = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
        t = 0;
        while (done_cnt == db && t < 8000) begin
            if (t >= hold_at && t < hold_at + hold_len) begin
                hold_a = 1'b1;
                #1;
                if (bus_a.mem_rd !== 1'b0 ||
                    bus_a.mem_addr !== 12'(addr_of(rd_addr_q.size() - rb, COLS)))
                    bad_frz++;
            end else begin
                hold_a = ($urandom_range(99) < pct);
            end
            @(posedge clk); #1;
            t++;
        end
        hold_a = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done pulses"}, done_cnt - db, 1);
        nrd = rd_addr_q.size() - rb;
        npx = pix_q.size() - pb;
        chk({tag, " reads"}, nrd, NPIX);
        chk({tag, " pixels"}, npx, NPIX);
        for (int k = 0; k < nrd && k < NPIX; k++)
            if (rd_addr_q[rb + k] != addr_of(k, COLS)) bad_addr++;
        for (int k = 0; k < npx && k < NPIX; k++)
            if (pix_q[pb + k] !== pix_of(k)) bad_pix++;
        for (int k = 0; k < npx && k < nrd; k++)
            if (pix_cyc_q[pb + k] != rd_cyc_q[rb + k] + 2) bad_lat++;
        chk({tag, " address errors"}, bad_addr, 0);
        chk({tag, " pixel/flag errors"}, bad_pix, 0);
        chk({tag, " latency errors"}, bad_lat, 0);
        if (hold_len > 0) chk({tag, " frozen address errors"}, bad_frz, 0);
        chk({tag, " reads while hold"}, rd_in_hold - rhb, 0);
        chk({tag, " flags without valid"}, side_bad - sb, 0);
        first_rd = (nrd > 0) ? rd_cyc_q[rb] : -1;
        last_rd  = (nrd > 0) ? rd_cyc_q[rb + nrd - 1] : -1;
        first_px = (npx > 0) ? pix_cyc_q[pb] : -1;
        last_px  = (npx > 0) ? pix_cyc_q[pb + npx - 1] : -1;
        for (int i = hb; i < hold_cyc_q.size(); i++) begin
            c = hold_cyc_q[i];
            if (c >= s_cyc + 1 && c <= last_rd) hw++;
            if (c > first_rd && c < last_rd) hi++;
        end
        if (hold_at > 0 && pct == 0) chk({tag, " first read cycle"}, first_rd, s_cyc + 1);
        chk({tag, " fetch stall cycles"}, last_rd - s_cyc - NPIX, hw);
        chk({tag, " pixel gaps"}, last_px - first_px + 1 - NPIX, (exp_gaps < 0) ? hi : exp_gaps);
        chk({tag, " done timing"}, done_cyc, last_px + 1);
    endtask

    typedef struct {
        int   idx;
        int   addr;
        logic first;
        logic brd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int rb, pb, t, act;
        tbl[0]  = '{0,    0,    1'b1, 1'b1};
        tbl[1]  = '{1,    1,    1'b0, 1'b1};
        tbl[2]  = '{7,    7,    1'b0, 1'b1};
        tbl[3]  = '{8,    48,   1'b0, 1'b1};
        tbl[4]  = '{15,   55,   1'b0, 1'b1};
        tbl[5]  = '{63,   343,  1'b0, 1'b1};
        tbl[6]  = '{64,   8,    1'b1, 1'b0};
        tbl[7]  = '{128,  16,   1'b1, 1'b0};
        tbl[8]  = '{320,  40,   1'b1, 1'b1};
        tbl[9]  = '{383,  383,  1'b0, 1'b1};
        tbl[10] = '{384,  384,  1'b1, 1'b1};
        tbl[11] = '{448,  392,  1'b1, 1'b0};
        tbl[12] = '{704,  424,  1'b1, 1'b1};
        tbl[13] = '{768,  768,  1'b1, 1'b1};
        tbl[14] = '{1000, 1032, 1'b0, 1'b0};
        tbl[15] = '{1472, 1192, 1'b1, 1'b1};
        tbl[16] = '{1535, 1535, 1'b0, 1'b1};

        for (int i = 0; i < 4096; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < 64; i++)   mem_b[i] = 8'($urandom);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_rd",    bus_a.mem_rd,    0);
        chk("reset mem_addr",  bus_a.mem_addr,  0);
        chk("reset pix_valid", bus_a.pix_valid, 0);
        chk("reset pix_data",  bus_a.pix_data,  0);
        chk("reset busy",      busy_a,          0);
        chk("reset done",      done_a,          0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Plain frame, then spot checks of the scan order and flags
        run_frame_a(0, 1000000, 0, 0, "plain", rb, pb);
        for (int i = 0; i < 17; i++) begin
            act = (rb + tbl[i].idx < rd_addr_q.size()) ? rd_addr_q[rb + tbl[i].idx] : -1;
            chk($sformatf("vec%0d addr", tbl[i].idx), act, tbl[i].addr);
            act = (pb + tbl[i].idx < pix_q.size()) ? int'(pix_q[pb + tbl[i].idx][9]) : -1;
            chk($sformatf("vec%0d blk_first", tbl[i].idx), act, tbl[i].first);
            act = (pb + tbl[i].idx < pix_q.size()) ? int'(pix_q[pb + tbl[i].idx][8]) : -1;
            chk($sformatf("vec%0d border", tbl[i].idx), act, tbl[i].brd);
        end

        // Five-cycle hold in the middle of block 0
        run_frame_a(0, 20, 5, 5, "hold5", rb, pb);

        // Random hold patterns
        for (int r = 0; r < 3; r++)
            run_frame_a(10 + 15 * r, 1000000, 0, -1, $sformatf("rand%0d", r), rb, pb);

        // Reset during block 10
        rb = rd_addr_q.size();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        t = 0;
        while (rd_addr_q.size() - rb < 650 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("midreset reached block 10", (rd_addr_q.size() - rb) >= 650, 1);
        #2 reset = 1'b0;
        #1;
        chk("midreset mem_rd",    bus_a.mem_rd,    0);
        chk("midreset mem_addr",  bus_a.mem_addr,  0);
        chk("midreset pix_valid", bus_a.pix_valid, 0);
        chk("midreset pix_data",  bus_a.pix_data,  0);
        chk("midreset blk_first", bus_a.blk_first, 0);
        chk("midreset border",    bus_a.border,    0);
        chk("midreset busy",      busy_a,          0);
        chk("midreset done",      done_a,          0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rb = rd_addr_q.size();
        pb = pix_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("after reset no pixels", pix_q.size() - pb, 0);
        chk("after reset no reads", rd_addr_q.size() - rb, 0);
        chk("after reset busy", busy_a, 0);
        run_frame_a(0, 1000000, 0, 0, "restart", rb, pb);
        chk("restart first addr", (rb < rd_addr_q.size()) ? rd_addr_q[rb] : -1, 0);

        // Single-block image, start held high across two frames
        start_b = 1'b1;
        t = 0;
        while (b_done_q.size() < 1 && t < 400) begin @(posedge clk); #1; t++; end
        t = 0;
        while (b_rd_q.size() < 65 && t < 50) begin @(posedge clk); #1; t++; end
        start_b = 1'b0;
        t = 0;
        while (b_done_q.size() < 2 && t < 400) begin @(posedge clk); #1; t++; end
        repeat (5) @(posedge clk);
        #1;
        chk("1x1 done pulses", b_done_q.size(), 2);
        chk("1x1 reads", b_rd_q.size(), 128);
        chk("1x1 pixels", b_pix, 128);
        chk("1x1 border count", b_brd, 128);
        chk("1x1 blk_first count", b_first, 2);
        chk("1x1 data errors", b_bad, 0);
        chk("1x1 flags without valid", b_side, 0);
        chk("1x1 idle busy", busy_b, 0);
        chk("1x1 frame1 contiguous", (b_rd_q.size() > 63) ? b_rd_q[63] - b_rd_q[0] : -1, 63);
        chk("1x1 relaunch cycle", (b_rd_q.size() > 64 && b_done_q.size() > 0) ?
            b_rd_q[64] - b_done_q[0] : -1, 2);
        chk("1x1 frame2 done cycle", (b_done_q.size() > 1) ? b_done_q[1] - b_done_q[0] : -1, 68);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
